pulse_measure: RTL and testbench

Downstream consumer of the pulse generator stage. Samples the asynchronous `signal` waveform through a two-flop synchronizer and detects its edges. Measures the high width and full period of each pulse in `clock` cycles and counts completed pulses. Each finished measurement is presented to the next stage over a valid/ready handshake.

---
 rtl/pulse_measure.sv | 114 +++++++++++
 tb/tb_pulse_measure.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_measure.sv
// pulse_measure: measures high width and period of a synchronized pulse train,
// presenting each finished measurement over a valid/ready handshake.
module pulse_measure #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    input  logic             enable,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] high_width,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             missed
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d, missed_q, missed_d, overflow_q, overflow_d;
    logic [WIDTH-1:0] high_width_q, high_width_d, period_q, period_d, count_q, count_d;
    logic             rise, fall, done, xfer, load;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == MAX) ? v : v + ONE;
    endfunction

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign done = enable && (state_q == LOW) && rise;
    assign xfer = valid_q & ready;
    // A completion is only kept when the result slot is free or being drained this edge
    assign load = done & (~valid_q | ready);

    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        ovf_d     = ovf_q;
        if (!enable) begin
            state_d   = IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
            ovf_d     = 1'b0;
        end else if (rise && state_q != HIGH) begin
            state_d   = HIGH;
            hi_cnt_d  = ONE;
            per_cnt_d = ONE;
            ovf_d     = 1'b0;
        end else if (state_q == HIGH) begin
            state_d   = fall ? LOW : HIGH;
            hi_cnt_d  = fall ? hi_cnt_q : sat_inc(hi_cnt_q);
            per_cnt_d = sat_inc(per_cnt_q);
            ovf_d     = ovf_q | (per_cnt_q == MAX) | (~fall & (hi_cnt_q == MAX));
        end else if (state_q == LOW) begin
            per_cnt_d = sat_inc(per_cnt_q);
            ovf_d     = ovf_q | (per_cnt_q == MAX);
        end
    end

    always_comb begin
        valid_d      = load | (valid_q & ~ready);
        missed_d     = ~xfer & (missed_q | (done & valid_q));
        high_width_d = load ? hi_cnt_q : high_width_q;
        period_d     = load ? per_cnt_q : period_q;
        overflow_d   = load ? ovf_q : overflow_q;
        count_d      = load ? count_q + ONE : count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= IDLE;
            hi_cnt_q     <= '0;
            per_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            missed_q     <= 1'b0;
            overflow_q   <= 1'b0;
            high_width_q <= '0;
            period_q     <= '0;
            count_q      <= '0;
        end else begin
            s1_q         <= signal;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            hi_cnt_q     <= hi_cnt_d;
            per_cnt_q    <= per_cnt_d;
            ovf_q        <= ovf_d;
            valid_q      <= valid_d;
            missed_q     <= missed_d;
            overflow_q   <= overflow_d;
            high_width_q <= high_width_d;
            period_q     <= period_d;
            count_q      <= count_d;
        end
    end

    assign valid      = valid_q;
    assign missed     = missed_q;
    assign overflow   = overflow_q;
    assign high_width = high_width_q;
    assign period     = period_q;
    assign count      = count_q;
endmodule

// File: tb/tb_pulse_measure.sv
// tb_pulse_measure: drives an 8-bit and a 4-bit pulse_measure from the same stimulus
// and checks both against a run-length model of the sampled waveform.
module tb_pulse_measure;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic signal = 1'b0;
    logic enable = 1'b1;
    logic ready = 1'b1;
    logic valid8, ovf8, mis8, valid4, ovf4, mis4;
    logic [7:0] hw8, per8, cnt8;
    logic [3:0] hw4, per4, cnt4;

    int total = 0;
    int bad = 0;

    pulse_measure #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .signal(signal), .enable(enable), .ready(ready),
        .valid(valid8), .high_width(hw8), .period(per8), .count(cnt8),
        .overflow(ovf8), .missed(mis8)
    );
    pulse_measure #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .signal(signal), .enable(enable), .ready(ready),
        .valid(valid4), .high_width(hw4), .period(per4), .count(cnt4),
        .overflow(ovf4), .missed(mis4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Model: the waveform value seen by the measurement at edge n is the sample taken at edge n-2.
    bit samp[$] = '{1'b0, 1'b0, 1'b0};
    int armed = 0, mh = 0, ml = 0, rh = 0, rl = 0, mcnt = 0;
    bit mvalid = 1'b0, mmissed = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed = 0; mh = 0; ml = 0; rh = 0; rl = 0; mcnt = 0;
            mvalid = 1'b0; mmissed = 1'b0;
            samp = '{1'b0, 1'b0, 1'b0};
        end else begin
            bit eff, rise, done, xfer;
            int ch, cl;
            eff  = samp[1];
            rise = eff && !samp[0];
            done = 1'b0;
            ch = 0; cl = 0;
            if (!enable) armed = 0;
            else if (rise) begin
                done = (armed != 0);
                ch = mh; cl = ml;
                armed = 1; mh = 1; ml = 0;
            end else if (armed != 0) begin
                if (eff) mh++;
                else ml++;
            end
            xfer = mvalid && ready;
            if (done && mvalid && !ready) mmissed = 1'b1;
            else begin
                if (xfer) begin
                    mvalid = 1'b0;
                    mmissed = 1'b0;
                end
                if (done) begin
                    mvalid = 1'b1;
                    rh = ch; rl = cl;
                    mcnt++;
                end
            end
            samp.push_back(signal);
            void'(samp.pop_front());
        end
    end

    always @(negedge clock) begin
        chk("valid8", valid8, mvalid);
        chk("valid4", valid4, mvalid);
        chk("missed8", mis8, mmissed);
        chk("missed4", mis4, mmissed);
        chk("hw8", hw8, sat(rh, 255));
        chk("per8", per8, sat(rh + rl, 255));
        chk("ovf8", ovf8, (rh + rl) > 255);
        chk("cnt8", cnt8, mcnt % 256);
        chk("hw4", hw4, sat(rh, 15));
        chk("per4", per4, sat(rh + rl, 15));
        chk("ovf4", ovf4, (rh + rl) > 15);
        chk("cnt4", cnt4, mcnt % 16);
    end

    typedef struct {int hw8, per8, ovf8, hw4, per4, ovf4;} res_t;
    res_t res[$];
    logic [7:0] pc = '0;

    always @(negedge clock) begin
        if (cnt8 !== pc) res.push_back('{int'(hw8), int'(per8), int'(ovf8), int'(hw4), int'(per4), int'(ovf4)});
        pc = cnt8;
    end

    function automatic res_t get_res(input int i);
        res_t r;
        r = '{-1, -1, -1, -1, -1, -1};
        if (i < res.size()) r = res[i];
        return r;
    endfunction

    task automatic pulse(input int h, input int l);
        signal = 1'b1;
        repeat (h) @(negedge clock);
        signal = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic abort_meas();
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        res_t r;
        int c0;
        bit lvl;
        int rem;
        repeat (6) begin
            @(negedge clock);
            signal = ~signal;
        end
        @(negedge clock);
        chk("rst_valid", valid8, 0);
        chk("rst_count", cnt8, 0);
        chk("rst_hw", hw8, 0);
        chk("rst_missed", mis8, 0);
        signal = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("post_rst_valid", valid8, 0);

        res.delete();
        repeat (4) pulse(5, 3);
        repeat (3) @(negedge clock);
        r = get_res(0);
        chk("basic_n", res.size(), 3);
        chk("basic_hw", r.hw8, 5);
        chk("basic_per", r.per8, 8);
        chk("basic_ovf", r.ovf8, 0);
        chk("basic_cnt", cnt8, 3);
        chk("basic_valid_drained", valid8, 0);

        abort_meas();
        ready = 1'b0;
        pulse(5, 3);
        pulse(6, 3);
        pulse(2, 2);
        repeat (3) @(negedge clock);
        chk("bp_valid", valid8, 1);
        chk("bp_missed", mis8, 1);
        chk("bp_cnt", cnt8, 4);
        chk("bp_hw", hw8, 5);
        chk("bp_per", per8, 8);
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        chk("bp_xfer_valid", valid8, 0);
        chk("bp_xfer_missed", mis8, 0);

        abort_meas();
        pulse(2, 2);
        pulse(2, 2);
        signal = 1'b1;
        repeat (2) @(negedge clock);
        ready = 1'b1;
        signal = 1'b0;
        @(negedge clock);
        ready = 1'b0;
        chk("sim_valid", valid8, 1);
        chk("sim_missed", mis8, 0);
        chk("sim_cnt", cnt8, 6);
        chk("sim_hw", hw8, 2);
        chk("sim_per", per8, 4);
        repeat (3) @(negedge clock);
        ready = 1'b1;
        @(negedge clock);

        abort_meas();
        res.delete();
        pulse(20, 2);
        pulse(3, 3);
        pulse(3, 3);
        repeat (3) @(negedge clock);
        chk("sat_n", res.size(), 2);
        r = get_res(0);
        chk("sat_hw4", r.hw4, 15);
        chk("sat_per4", r.per4, 15);
        chk("sat_ovf4", r.ovf4, 1);
        chk("sat_hw8", r.hw8, 20);
        chk("sat_per8", r.per8, 22);
        chk("sat_ovf8", r.ovf8, 0);
        r = get_res(1);
        chk("post_sat_hw4", r.hw4, 3);
        chk("post_sat_per4", r.per4, 6);
        chk("post_sat_ovf4", r.ovf4, 0);

        abort_meas();
        c0 = int'(cnt8);
        signal = 1'b1;
        repeat (4) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        signal = 1'b0;
        repeat (3) @(negedge clock);
        pulse(5, 3);
        chk("abort_no_result", cnt8, c0);
        signal = 1'b1;
        repeat (3) @(negedge clock);
        chk("abort_second_rise_cnt", cnt8, c0 + 1);
        chk("abort_hw", hw8, 5);
        chk("abort_per", per8, 8);
        signal = 1'b0;
        repeat (3) @(negedge clock);

        lvl = 1'b0;
        rem = 0;
        for (int i = 0; i < 900; i++) begin
            if (rem == 0) begin
                lvl = ~lvl;
                rem = $urandom_range(1, 18);
            end
            rem--;
            ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 80) != 0);
            #($urandom_range(0, 3)) signal = lvl;
            @(negedge clock);
        end
        enable = 1'b1;
        signal = 1'b0;
        ready = 1'b1;
        repeat (4) @(negedge clock);

        abort_meas();
        ready = 1'b0;
        pulse(3, 3);
        signal = 1'b1;
        repeat (3) @(negedge clock);
        signal = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_rst_valid", valid8, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid8", valid8, 0);
        chk("arst_hw8", hw8, 0);
        chk("arst_per8", per8, 0);
        chk("arst_cnt8", cnt8, 0);
        chk("arst_ovf8", ovf8, 0);
        chk("arst_missed8", mis8, 0);
        chk("arst_valid4", valid4, 0);
        chk("arst_cnt4", cnt4, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
